// File: rtl/iir_biquad_seq.sv
// iir_biquad_seq: time-multiplexed biquad IIR with a shared multiplier and double-buffered coefficients.
// Define IIR_SEQ_SAT_EN to saturate dout and pulse ovf; otherwise dout wraps and ovf stays 0.
module iir_biquad_seq #(
  parameter int          WIDTH    = 14,
  parameter logic [15:0] COEFF_B0 = 16'h0292,
  parameter logic [15:0] COEFF_B1 = 16'h0524,
  parameter logic [15:0] COEFF_B2 = 16'h0292,
  parameter logic [15:0] COEFF_A1 = 16'hC7CF,
  parameter logic [15:0] COEFF_A2 = 16'hADE8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    din_valid,
  input  logic signed [WIDTH-1:0] din,
  output logic                    din_ready,
  output logic                    dout_valid,
  output logic signed [WIDTH+15:0] dout,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_addr,
  input  logic [15:0]             cfg_wdata,
  input  logic                    cfg_commit,
  output logic                    cfg_pending,
  output logic                    ovf
);
  localparam int YW = WIDTH + 16;
  localparam int PW = YW + 16;
  localparam int AW = WIDTH + 35;
  localparam int RW = AW - 15;
  localparam logic [4:0][15:0] C_DEF =
    {COEFF_A2, COEFF_A1, COEFF_B2, COEFF_B1, COEFF_B0};

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, WB} state_t;

  state_t               r_state;
  logic [2:0]           r_step;
  logic signed [YW-1:0] r_x0, r_x1, r_x2, r_y1, r_y2;
  logic signed [PW-1:0] r_prod;
  logic                 r_pv, r_psub;
  logic signed [AW-1:0] r_acc;
  logic [4:0][15:0]     r_sh, r_act;
  logic                 r_pend;
  logic signed [YW-1:0] r_dout;
  logic                 r_vld, r_ovf;

  logic [4:0][15:0]     w_sh_nxt;
  logic                 w_copy;
  logic signed [YW-1:0] w_opa;
  logic signed [15:0]   w_coef;
  logic                 w_sub;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_pext;
  logic signed [RW-1:0] w_r;
  logic signed [YW-1:0] w_rs;
  logic                 w_clip;

  assign din_ready   = (r_state == IDLE);
  assign dout_valid  = r_vld;
  assign dout        = r_dout;
  assign cfg_pending = r_pend;
  assign ovf         = r_ovf;

  // A write in the same cycle as the copy must land in the active bank.
  always_comb begin
    w_sh_nxt = r_sh;
    if (cfg_we && (cfg_addr < 3'd5))
      w_sh_nxt[cfg_addr] = cfg_wdata;
  end

  assign w_copy = (r_state == IDLE) && (r_pend || cfg_commit);

  always_comb begin
    w_opa  = r_x0;
    w_coef = r_act[0];
    w_sub  = 1'b0;
    unique case (r_step)
      3'd1: begin w_opa = r_x1; w_coef = r_act[1]; end
      3'd2: begin w_opa = r_x2; w_coef = r_act[2]; end
      3'd3: begin w_opa = r_y1; w_coef = r_act[3]; w_sub = 1'b1; end
      3'd4: begin w_opa = r_y2; w_coef = r_act[4]; w_sub = 1'b1; end
      default: ;
    endcase
  end

  assign w_prod = w_opa * w_coef;
  assign w_pext = {{(AW-PW){r_prod[PW-1]}}, r_prod};
  assign w_r    = r_acc[AW-1:15];

`ifdef IIR_SEQ_SAT_EN
  localparam logic signed [YW-1:0] YMAX = {1'b0, {(YW-1){1'b1}}};
  localparam logic signed [YW-1:0] YMIN = {1'b1, {(YW-1){1'b0}}};
  always_comb begin
    w_rs   = w_r[YW-1:0];
    w_clip = 1'b0;
    if (!((&w_r[RW-1:YW-1]) || !(|w_r[RW-1:YW-1]))) begin
      w_clip = 1'b1;
      w_rs   = w_r[RW-1] ? YMIN : YMAX;
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_r[RW-1:YW];
  assign w_rs        = w_r[YW-1:0];
  assign w_clip      = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_y1    <= '0;
      r_y2    <= '0;
      r_prod  <= '0;
      r_pv    <= 1'b0;
      r_psub  <= 1'b0;
      r_acc   <= '0;
      r_sh    <= C_DEF;
      r_act   <= C_DEF;
      r_pend  <= 1'b0;
      r_dout  <= '0;
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_pv  <= 1'b0;
      r_vld <= 1'b0;
      r_ovf <= 1'b0;
      r_sh  <= w_sh_nxt;
      r_pend <= w_copy ? 1'b0 : (r_pend | cfg_commit);
      if (w_copy)
        r_act <= w_sh_nxt;
      // Product from the previous step is folded in one cycle late.
      if (r_pv)
        r_acc <= r_psub ? (r_acc - w_pext) : (r_acc + w_pext);
      unique case (r_state)
        IDLE: begin
          if (din_valid) begin
            r_x2    <= r_x1;
            r_x1    <= r_x0;
            r_x0    <= {{16{din[WIDTH-1]}}, din};
            r_acc   <= '0;
            r_step  <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_prod <= w_prod;
          r_pv   <= 1'b1;
          r_psub <= w_sub;
          if (r_step == 3'd4)
            r_state <= DRAIN;
          else
            r_step <= r_step + 3'd1;
        end
        DRAIN: r_state <= WB;
        WB: begin
          r_dout  <= w_rs;
          r_y2    <= r_y1;
          r_y1    <= w_rs;
          r_vld   <= 1'b1;
          r_ovf   <= w_clip;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// tb_iir_biquad_seq: directed bench for iir_biquad_seq.
// Sat/wrap expectations follow IIR_SEQ_SAT_EN.
module tb_iir_biquad_seq;
  localparam int W = 14;

  logic                  clk = 1'b0;
  logic                  n_rst = 1'b0;
  logic                  din_valid = 1'b0;
  logic signed [W-1:0]   din = '0;
  logic                  din_ready;
  logic                  dout_valid;
  logic signed [W+15:0]  dout;
  logic                  cfg_we = 1'b0;
  logic [2:0]            cfg_addr = '0;
  logic [15:0]           cfg_wdata = '0;
  logic                  cfg_commit = 1'b0;
  logic                  cfg_pending;
  logic                  ovf;

  int     checks = 0;
  int     errors = 0;
  longint y, ov;
  int     lat, rlow;
  longint y1m, y2m, accm, rm, expc;
  int     seen_neg, seen_ovf;

  iir_biquad_seq #(.WIDTH(W)) dut (
    .clk(clk), .n_rst(n_rst),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout(dout),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cw(input int a, input logic [15:0] d);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic send(input int x, input logic mc,
                      output longint yo, output longint oo,
                      output int lo, output int ro);
    din = W'(x);
    din_valid = 1'b1;
    @(posedge clk);
    lo = -1;
    ro = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) din_valid = 1'b0;
      if (mc && n == 1) begin
        cfg_we = 1'b1; cfg_addr = 3'd0;
        cfg_wdata = 16'h2000; cfg_commit = 1'b1;
      end
      if (mc && n == 2) begin
        cfg_we = 1'b0; cfg_commit = 1'b0;
        chk("pending_in_mac", cfg_pending, 1);
      end
      if (dout_valid) begin
        lo = n;
        break;
      end
      if (!din_ready) ro++;
    end
    chk("dout_valid_seen", longint'(lo >= 0), 1);
    yo = dout;
    oo = ovf;
  endtask

  task automatic flush();
    for (int a = 0; a < 5; a++) cw(a, 16'h0000);
    commit();
    for (int k = 0; k < 2; k++) begin
      send(0, 1'b0, y, ov, lat, rlow);
      chk("flush", y, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_ready", din_ready, 1);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_ovf", ovf, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // b0 = 0.5
    cw(0, 16'h4000); cw(1, 0); cw(2, 0); cw(3, 0); cw(4, 0);
    commit();
    send(1000, 1'b0, y, ov, lat, rlow);
    chk("b0_dout", y, 500);
    chk("b0_latency", lat, 7);
    chk("b0_ready_low", rlow, 7);
    chk("b0_ovf", ov, 0);
    @(negedge clk);
    chk("valid_one_cycle", dout_valid, 0);

    // b1 = 0.5, x history holds the previous 1000
    cw(0, 16'h0000); cw(1, 16'h4000);
    commit();
    send(0, 1'b0, y, ov, lat, rlow);    chk("b1_hist", y, 500);
    send(0, 1'b0, y, ov, lat, rlow);    chk("b1_zero", y, 0);
    send(1000, 1'b0, y, ov, lat, rlow); chk("b1_first", y, 0);
    send(0, 1'b0, y, ov, lat, rlow);    chk("b1_delay", y, 500);

    // one-pole feedback, a1 = -0.5
    flush();
    cw(0, 16'h4000); cw(3, 16'hC000);
    commit();
    send(1000, 1'b0, y, ov, lat, rlow); chk("fb0", y, 500);
    send(0, 1'b0, y, ov, lat, rlow);    chk("fb1", y, 250);
    send(0, 1'b0, y, ov, lat, rlow);    chk("fb2", y, 125);
    send(0, 1'b0, y, ov, lat, rlow);    chk("fb3", y, 62);
    send(0, 1'b0, y, ov, lat, rlow);    chk("fb4", y, 31);

    // commit during MAC takes effect on the next sample
    flush();
    cw(0, 16'h4000);
    commit();
    send(1000, 1'b1, y, ov, lat, rlow);
    chk("mid_commit_old", y, 500);
    chk("pending_at_idle", cfg_pending, 1);
    @(negedge clk);
    chk("pending_cleared", cfg_pending, 0);
    send(1000, 1'b0, y, ov, lat, rlow);
    chk("mid_commit_new", y, 250);

    // reset during MAC step 2
    din = 14'sd1000;
    din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    chk("pending_pre_rst", cfg_pending, 1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("mrst_dout", dout, 0);
    chk("mrst_valid", dout_valid, 0);
    chk("mrst_ready", din_ready, 1);
    chk("mrst_pending", cfg_pending, 0);
    chk("mrst_ovf", ovf, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    send(1000, 1'b0, y, ov, lat, rlow); chk("dflt0", y, 20);
    send(1000, 1'b0, y, ov, lat, rlow); chk("dflt1", y, 69);

    // runaway feedback: saturate or wrap
    flush();
    cw(0, 16'h7FFF); cw(3, 16'h8000); cw(4, 16'h8000);
    commit();
    y1m = 0; y2m = 0; seen_neg = 0; seen_ovf = 0;
    for (int s = 0; s < 50; s++) begin
      send(8191, 1'b0, y, ov, lat, rlow);
      accm = 64'sd32767 * 64'sd8191 + 64'sd32768 * y1m + 64'sd32768 * y2m;
      rm = accm >>> 15;
      expc = 0;
`ifdef IIR_SEQ_SAT_EN
      if (rm > 64'sd536870911) begin rm = 64'sd536870911; expc = 1; end
      if (rm < -64'sd536870912) begin rm = -64'sd536870912; expc = 1; end
`else
      rm = (rm << 34) >>> 34;
`endif
      chk("sat_dout", y, rm);
      chk("sat_ovf", ov, expc);
      if (y < 0) seen_neg = 1;
      if (ov != 0) seen_ovf = 1;
      y2m = y1m;
      y1m = rm;
    end
`ifdef IIR_SEQ_SAT_EN
    chk("sat_hold", y, 536870911);
    chk("sat_ovf_seen", seen_ovf, 1);
`else
    chk("wrap_neg_seen", seen_neg, 1);
    chk("wrap_no_ovf", seen_ovf, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_biquad_seq.md
# iir_biquad_seq

Time-multiplexed biquad IIR sequencer for the filter chain. It computes y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2] with one shared signed multiplier, stepping through five MAC cycles per sample. It also owns the Q1.15 coefficient bank, which is double-buffered and committed only at sample boundaries. It sits between the ADC sample stream (valid/ready) and downstream decimation/demodulation logic.

## Interface
- WIDTH, 14, input sample width (signed)
- COEFF_B0, 16'h0292, reset value of b0 (Q1.15)
- COEFF_B1, 16'h0524, reset value of b1
- COEFF_B2, 16'h0292, reset value of b2
- COEFF_A1, 16'hC7CF, reset value of a1
- COEFF_A2, 16'hADE8, reset value of a2
- clk  in  1  clock
- n_rst  in  1  reset; asynchronous, active-low
- din_valid  in  1  input sample valid
- din  in  WIDTH  signed input sample
- din_ready  out  1  sequencer can accept a sample (combinational: state==IDLE)
- dout_valid  out  1  one-cycle pulse, dout updated
- dout  out  WIDTH+16  signed output y[n]
- cfg_we  in  1  shadow coefficient write strobe
- cfg_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 ignored
- cfg_wdata  in  16  Q1.15 coefficient
- cfg_commit  in  1  request shadow→active copy
- cfg_pending  out  1  commit requested, not yet applied
- ovf  out  1  one-cycle pulse, output saturated (see Configuration)

## Operation
- FSM states: IDLE → MAC (5 cycles, step 0..4) → DRAIN (1) → WB (1) → IDLE.
- IDLE, din_valid & din_ready:
  - shift x2←x1, x1←x0, x0←din;
  - clear acc;
  - go to MAC.
- MAC step order: b0·x0, b1·x1, b2·x2, a1·y1, a2·y2.
  - Multiplier operand A is WIDTH+16 bits, with x sign-extended.
  - The product is registered, then accumulated one cycle later: add for b terms, subtract for a terms.
  - DRAIN absorbs the final product.
- Accumulator: WIDTH+35 bits signed, full precision, no intermediate truncation.
- WB:
  - r = acc >>> 15 (arithmetic shift, floor, no rounding);
  - r is saturated or wrapped to WIDTH+16 bits;
  - dout←r, y2←y1, y1←r;
  - dout_valid←1 for one cycle.
- Coefficients:
  - cfg_we writes the shadow register for addr 0–4 on any cycle, in any state.
  - cfg_commit sets cfg_pending.
  - The active bank copies from shadow on the first edge where state==IDLE and pending=1 (or commit=1 that cycle); pending clears on that edge.
- Simultaneous events:
  - we+commit same cycle: the write is included in the copy.
  - Copy on the same edge as din acceptance: that sample uses the new coefficients.
  - Commit during MAC/DRAIN/WB: the in-flight sample finishes with the old bank.
- Reset (also mid-sample): abort the sample. State→IDLE. x0..x2, y1, y2, acc, dout=0. dout_valid=0, cfg_pending=0, ovf=0. Shadow and active banks = parameter defaults.

## Timing
- Accept edge E0 → MAC on E0..E5 → DRAIN → WB.
- dout/dout_valid valid in the cycle after edge E7: latency 7 clocks.
- din_ready low from E0 until state returns to IDLE. The next accept is at E8 at the earliest, so minimum sample period is 8 clocks.
- din is ignored while din_ready=0; the upstream side holds din_valid.
- cfg_pending rises the cycle after cfg_commit and falls the cycle after the copy edge.

## Configuration
- Macro IIR_SEQ_SAT_EN.
- Defined: r is clamped to [−2^(WIDTH+15), 2^(WIDTH+15)−1], and ovf pulses with dout_valid when clamping occurred.
- Undefined: r is truncated to its low WIDTH+16 bits (two's-complement wrap), and ovf is tied 0.

## Test plan
- b0=16'h4000, others 0, commit, din=1000 → dout=500, dout_valid exactly 7 clocks after accept, din_ready low 7 cycles.
- b1=16'h4000, others 0, din 1000 then 0 → dout 0 then 500.
- b0=16'h4000, a1=16'hC000, impulse 1000 then zeros → dout 500, 250, 125, 62, 31 (floor).
- b0=16'h7FFF, a1=a2=16'h8000, din constant 8191:
  - macro defined → dout reaches 536870911 within 50 samples and holds, ovf pulses;
  - macro undefined → dout wraps negative, ovf=0.
- Write b0=16'h2000 and commit during MAC of sample k → sample k uses the old b0, sample k+1 the new b0; cfg_pending high until the IDLE copy edge.
- Deassert n_rst during MAC step 2 → dout=0, dout_valid=0, din_ready=1, coefficients revert to defaults; the first sample after release matches the default-coefficient model.
